// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the processor-to-byte-SRAM data-memory bridge.
package dmem_bridge_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int DMEM_DEPTH     = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Big-endian lane select: index 0 is the most significant byte of the word.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [31:0] word,
                                                  input logic [1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_byte_bridge.sv
// Serialises one 32-bit load/store into four big-endian byte SRAM accesses; store 5 cycles, load 6, misaligned 1.
// The requester is stalled (no cpu_ready) until the word completes; a request held through DONE restarts next cycle.
module dmem_byte_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = $clog2(DMEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_wr,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [BYTE_W-1:0]         mem_rdata
);

  localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);
  localparam logic [2:0] CAP_LAST = 3'(BYTES_PER_WORD);

  state_t                    state;
  logic [1:0]                cnt;
  logic [1:0]                cnt_nxt;
  logic [2:0]                cap;
  logic [MEM_ADDR_WIDTH-3:0] base_word;
  logic [31:0]               wdata_q;
  logic [23:0]               asm_q;

  // Addresses wrap modulo the SRAM size, so the high request bits are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[31:MEM_ADDR_WIDTH];

  assign cnt_nxt = cnt + 2'd1;

  // Aligned words never straddle the top of memory, so the byte offset is just concatenated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      cap       <= 3'd0;
      base_word <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            base_word <= cpu_addr[MEM_ADDR_WIDTH-1:2];
            wdata_q   <= cpu_wdata;
            cnt       <= 2'd0;
            cap       <= 3'd0;
            if (cpu_addr[1:0] != 2'b00) begin
              state     <= DONE;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
            end else if (cpu_wr) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_addr  <= {cpu_addr[MEM_ADDR_WIDTH-1:2], 2'd0};
              mem_wdata <= word_byte(cpu_wdata, 2'd0);
            end else begin
              state    <= RD;
              mem_re   <= 1'b1;
              mem_addr <= {cpu_addr[MEM_ADDR_WIDTH-1:2], 2'd0};
            end
          end
        end

        WR: begin
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ready <= 1'b1;
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= {base_word, cnt_nxt};
            mem_wdata <= word_byte(wdata_q, cnt_nxt);
          end
        end

        RD: begin
          // Issue runs one cycle ahead of capture; cap counts cycles spent in RD.
          cap <= cap + 3'd1;
          if (cap != 3'd0) begin
            asm_q <= {asm_q[15:0], mem_rdata};
          end
          if (cnt == CNT_LAST) begin
            mem_re   <= 1'b0;
            mem_addr <= '0;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= {base_word, cnt_nxt};
          end
          if (cap == CAP_LAST) begin
            state     <= DONE;
            cpu_rdata <= {asm_q, mem_rdata};
            cpu_ready <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Bench for dmem_byte_bridge: behavioural byte SRAM, word-level reference model, queued expectations
// checked by an independent monitor (SRAM access order/timing, completion timing, load data, error).
module tb_dmem_byte_bridge;
  import dmem_bridge_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;

  dmem_byte_bridge #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Behavioural 1024 x 8 synchronous SRAM.
  logic [7:0] sram [DMEM_DEPTH];
  logic       sram_load = 1'b1;
  always @(posedge clk) begin
    if (sram_load) begin
      for (int i = 0; i < DMEM_DEPTH; i++) sram[i] <= init_pat(i);
    end else begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    dat;
  } acc_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  acc_t        acc_q[$];
  rsp_t        rsp_q[$];
  logic [7:0]  ref_mem [DMEM_DEPTH];
  logic [31:0] ref_rdata = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    check({tag, "_cpu_err"},   32'(cpu_err),   32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata,      32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_re"},    32'(mem_re),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // Called just after a rising edge: this cycle is cycle 0 of the request.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit hold);
    int   c0;
    int   a;
    logic got;
    rsp_t r;
    acc_t x;
    c0        = cyc;
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    a = int'(addr % 32'(DMEM_DEPTH));
    if (addr[1:0] != 2'b00) begin
      r.cyc = c0 + 1; r.err = 1'b1; r.rdata = ref_rdata;
    end else begin
      for (int i = 0; i < 4; i++) begin
        x.cyc  = c0 + 1 + i;
        x.we   = wr;
        x.addr = AW'((a + i) % DMEM_DEPTH);
        x.dat  = wr ? 8'(wdata >> (8 * (3 - i))) : 8'h00;
        acc_q.push_back(x);
        if (wr) ref_mem[(a + i) % DMEM_DEPTH] = x.dat;
        else    ref_rdata = {ref_rdata[23:0], ref_mem[(a + i) % DMEM_DEPTH]};
      end
      r.cyc = c0 + (wr ? 5 : 6); r.err = 1'b0; r.rdata = ref_rdata;
    end
    rsp_q.push_back(r);
    @(posedge clk); #1;
    // Request fields are only sampled in cycle 0; scrambling them must not matter.
    cpu_wr    = 1'($urandom);
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = cpu_ready;
    end
    check("ready_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  // Monitor: SRAM drive rules, access sequence and completions against the queues.
  acc_t mon_acc;
  rsp_t mon_rsp;
  always @(negedge clk) begin
    if (rst_n && !sram_load) begin
      check("we_re_exclusive", 32'(mem_we && mem_re), 32'd0);
      check("err_only_with_ready", 32'(cpu_err && !cpu_ready), 32'd0);
      if (!mem_we) check("idle_wdata", 32'(mem_wdata), 32'd0);
      if (!mem_we && !mem_re) check("idle_addr", 32'(mem_addr), 32'd0);
      if (mem_we || mem_re) begin
        check("access_expected", 32'(acc_q.size() > 0), 32'd1);
        if (acc_q.size() > 0) begin
          mon_acc = acc_q.pop_front();
          check("access_cycle", 32'(cyc), 32'(mon_acc.cyc));
          check("access_is_write", 32'(mem_we), 32'(mon_acc.we));
          check("access_addr", 32'(mem_addr), 32'(mon_acc.addr));
          if (mon_acc.we) check("access_wdata", 32'(mem_wdata), 32'(mon_acc.dat));
        end
      end
      if (cpu_ready) begin
        check("ready_expected", 32'(rsp_q.size() > 0), 32'd1);
        if (rsp_q.size() > 0) begin
          mon_rsp = rsp_q.pop_front();
          check("ready_cycle", 32'(cyc), 32'(mon_rsp.cyc));
          check("ready_err", 32'(cpu_err), 32'(mon_rsp.err));
          check("ready_rdata", cpu_rdata, mon_rsp.rdata);
          check("accesses_complete", 32'(acc_q.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  acc_t rx;
  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) ref_mem[i] = init_pat(i);
    repeat (2) @(posedge clk);
    #1;
    sram_load = 1'b0;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, 32'h0000_0010, 32'h1234_ABCD, 1'b0);
    issue(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("load_0x10", cpu_rdata, 32'h1234_ABCD);
    issue(1'b0, 32'h0000_0022, 32'h0, 1'b0);
    check("misaligned_keeps_rdata", cpu_rdata, 32'h1234_ABCD);
    issue(1'b1, 32'h0004_03FC, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h0000_03FC, 32'h0, 1'b0);
    check("wrap_load_0x3fc", cpu_rdata, 32'hDEAD_BEEF);

    // Held request: second store's first write must land in cycle 7 of the first.
    issue(1'b1, 32'h0000_0080, 32'h0102_0304, 1'b1);
    issue(1'b1, 32'h0000_0084, 32'h0506_0708, 1'b0);

    // Reset after the first two byte writes of a store to 0x40.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hAABB_CCDD;
    for (int i = 0; i < 2; i++) begin
      rx.cyc = cyc + 1 + i; rx.we = 1'b1; rx.addr = AW'(32'h40 + i);
      rx.dat = (i == 0) ? 8'hAA : 8'hBB;
      acc_q.push_back(rx);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    check("midreset_pending_accesses", 32'(acc_q.size()), 32'd0);
    ref_mem[32'h40] = 8'hAA;
    ref_mem[32'h41] = 8'hBB;
    ref_rdata = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    check("after_reset_load_0x40", cpu_rdata, {8'hAA, 8'hBB, init_pat(32'h42), init_pat(32'h43)});

    for (int n = 0; n < 50; n++) begin
      logic        wr;
      logic [31:0] a;
      bit          hold;
      wr   = 1'($urandom);
      a    = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(31, 0)) << 2);
      if ($urandom_range(7, 0) == 0) a[1:0] = 2'($urandom_range(3, 1));
      hold = ($urandom_range(3, 0) == 0);
      issue(wr, a, $urandom, hold);
      if (!hold) repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
    end
    cpu_req = 1'b0;

    repeat (8) @(posedge clk);
    #1;
    check("queues_drained", 32'(acc_q.size() + rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
